regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
//
// PURPOSE
//   Shares one 8-entry x 32-bit register array between two requesters.
//   Round-robin arbitration with a valid/ready request handshake.
//   Fully serialised read and write access, with a one-cycle response pulse per requester.
//   Sits between the FSM-generated compute blocks and their shared scratch array.
//   Only this block reads or writes the array.
//
// PARAMETERS
//   DATA_W  32  array word width and data port width
//   ADDR_W  3   address width; array depth = 2**ADDR_W (8 by default)
//
// PORTS
//   clk          input   1       clock; all state updates on posedge
//   reset        input   1       asynchronous, active-low reset (0 = in reset)
//   req0_valid   input   1       requester 0 has a request pending
//   req0_we      input   1       1 = write, 0 = read
//   req0_addr    input   ADDR_W  array index
//   req0_wdata   input   DATA_W  write data; ignored when req0_we = 0
//   req0_ready   output  1       request 0 accepted this cycle
//   rsp0_valid   output  1       one-cycle response pulse to requester 0
//   rsp0_rdata   output  DATA_W  read data; for writes, echoes the written word
//   req1_*/rsp1_*  same set and widths for requester 1
//   busy         output  1       1 while a request is in flight (state != IDLE)
//
// BEHAVIOUR
// - Reset (reset = 0, async):
//   - fsmState = IDLE; all array words = 0; last_grant = 1.
//   - reqN_ready = 0, rspN_valid = 0, rspN_rdata = 0, busy = 0.
//   - Reset mid-operation: any in-flight request is dropped; no response is issued.
// - States:
//   - IDLE: if no valid, stay.
//     - Else pick a winner: the sole valid requester, or on a tie the one != last_grant.
//     - Assert winner's reqN_ready combinationally this cycle (never both).
//     - Latch we/addr/wdata/id; last_grant <= winner; go to ACCESS.
//   - ACCESS: write -> arr[addr] <= wdata and rdata_q <= wdata; read -> rdata_q <= arr[addr]. Go to RESP.
//   - RESP: rsp[id]_valid = 1 and rsp[id]_rdata = rdata_q for exactly one cycle; go to IDLE.
//     No request is accepted in RESP.
// - Timing:
//   - Handshake at cycle T (valid && ready) -> rsp_valid at T+2.
//   - Next accept no earlier than T+3; peak throughput 1 request per 3 cycles.
// - Handshake rules:
//   - Requester holds valid/we/addr/wdata stable until ready.
//   - ready never depends on rsp state; a loser keeps valid and wins next IDLE.
// - rspN_rdata holds its last value between pulses; it reads 0 only after reset.
// - Ordering: requests are serialised, so a read accepted after a write (either requester)
//   returns the written data.
// - Same address from both requesters: no conflict; handled in grant order.
// - Address wraps naturally within ADDR_W; there is no out-of-range case.
// - busy = 1 in ACCESS and RESP, 0 in IDLE.
//
// TESTING
// - Reset: after reset, read addr 5 via req0 -> rsp0_valid at T+2, rsp0_rdata = 0.
// - Write/read: req0 writes 0xDEADBEEF to addr 3, then req1 reads addr 3
//   -> rsp1_rdata = 0xDEADBEEF; rsp0 echoes 0xDEADBEEF.
// - Tie: both valid in the first IDLE after reset -> req0 granted first, req1 next (accept 3 cycles later).
//   Both held continuously -> grants strictly alternate 0,1,0,1.
// - Single requester: req1 held valid with 4 back-to-back reads
//   -> accepts at T, T+3, T+6, T+9; each rsp1_valid exactly 1 cycle.
// - Reset mid-op: assert reset in ACCESS of a write to addr 2
//   -> no rsp pulse; busy = 0 immediately; arr[2] reads back 0.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// Request/response bundle for the two requesters sharing the scratch register array.
// The arbiter takes the slave view; requesters (or a bench) take the master view.
interface regfile_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 2**ADDR_W x DATA_W register array.
// Every access runs IDLE -> ACCESS -> RESP, so requests are fully serialised.
module regfile_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    regfile_arbiter_if.slave    bus,
    output logic                busy
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              last_grant;
    logic              grant_en;
    logic              grant_id;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              id_q;

    logic [DATA_W-1:0] arr [DEPTH];
    logic [DATA_W-1:0] access_data;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        state_nxt      = state;
        grant_en       = 1'b0;
        grant_id       = last_grant;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.req0_valid || bus.req1_valid) begin
                    grant_en  = 1'b1;
                    grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_grant
                                                                   : bus.req1_valid;
                    state_nxt = ACCESS;
                    if (grant_id) begin
                        bus.req1_ready = 1'b1;
                    end else begin
                        bus.req0_ready = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp0_valid = ~id_q;
                bus.rsp1_valid = id_q;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A write answers with the word it stored.
    always_comb begin
        access_data = we_q ? wdata_q : arr[addr_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            id_q       <= 1'b0;
        end else if (grant_en) begin
            last_grant <= grant_id;
            id_q       <= grant_id;
            if (grant_id) begin
                we_q    <= bus.req1_we;
                addr_q  <= bus.req1_addr;
                wdata_q <= bus.req1_wdata;
            end else begin
                we_q    <= bus.req0_we;
                addr_q  <= bus.req0_addr;
                wdata_q <= bus.req0_wdata;
            end
        end
    end

    // Per-requester response words are loaded in ACCESS, shown during RESP and
    // then simply held, so each port keeps its last returned value between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                arr[i] <= '0;
            end
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state == ACCESS) begin
            if (we_q) begin
                arr[addr_q] <= wdata_q;
            end
            if (id_q) begin
                rdata1_q <= access_data;
            end else begin
                rdata0_q <= access_data;
            end
        end
    end

    assign bus.rsp0_rdata = rdata0_q;
    assign bus.rsp1_rdata = rdata1_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a negedge monitor keeps a reference array and
// per-requester response queues; directed steps check grant order and timing.
module tb_regfile_arbiter;
    localparam int DW = 32;
    localparam int AW = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    int unsigned cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem [8];
    int          gid[$];
    int unsigned gcyc[$];

    regfile_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (!reset) begin
            q0.delete();
            q1.delete();
            foreach (mem[i]) mem[i] = '0;
        end else begin
            check("ready_exclusive", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.rsp0_valid) begin
                if (q0.size() == 0) begin
                    check("rsp0_spurious_qsize", q0.size(), 32'd1);
                end else begin
                    e = q0.pop_front();
                    check("rsp0_data", bus.rsp0_rdata, e.data);
                    check("rsp0_cycle", cyc, e.cyc);
                    check("rsp0_busy", 32'(busy), 32'd1);
                end
            end
            if (bus.rsp1_valid) begin
                if (q1.size() == 0) begin
                    check("rsp1_spurious_qsize", q1.size(), 32'd1);
                end else begin
                    e = q1.pop_front();
                    check("rsp1_data", bus.rsp1_rdata, e.data);
                    check("rsp1_cycle", cyc, e.cyc);
                    check("rsp1_busy", 32'(busy), 32'd1);
                end
            end
            if (bus.req0_valid && bus.req0_ready) begin
                e.data = bus.req0_we ? bus.req0_wdata : mem[bus.req0_addr];
                e.cyc  = cyc + 2;
                q0.push_back(e);
                if (bus.req0_we) mem[bus.req0_addr] = bus.req0_wdata;
                gid.push_back(0);
                gcyc.push_back(cyc);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                e.data = bus.req1_we ? bus.req1_wdata : mem[bus.req1_addr];
                e.cyc  = cyc + 2;
                q1.push_back(e);
                if (bus.req1_we) mem[bus.req1_addr] = bus.req1_wdata;
                gid.push_back(1);
                gcyc.push_back(cyc);
            end
        end
    endtask

    task automatic drive(input int id, input logic we, input logic [2:0] a, input logic [31:0] d);
        if (id == 0) begin
            bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_valid = 1'b1;
        end
    endtask

    task automatic drop(input int id);
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (gid.size() < n && k < 60) begin
            @(negedge clk); #1;
            k++;
        end
        check("grant_count", gid.size(), n);
    endtask

    task automatic drain();
        int k = 0;
        while ((q0.size() + q1.size()) != 0 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        check("drain", q0.size() + q1.size(), 32'd0);
    endtask

    task automatic req_once(input int id, input logic we, input logic [2:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #2;
        drive(id, we, a, d);
        n = gid.size() + 1;
        wait_grants(n);
        if (gid.size() > 0) check("grant_id", gid[gid.size()-1], id);
        @(posedge clk); #2;
        drop(id);
        drain();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        drop(0);
        drop(1);
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus.req1_ready), 32'd0);
        check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("rst_rsp0_rdata", bus.rsp0_rdata, 32'd0);
        check("rst_rsp1_rdata", bus.rsp1_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
    endtask

    initial begin
        int          base;
        int          w;
        logic [2:0]  rd_addr [4];
        rd_addr[0] = 3'd6; rd_addr[1] = 3'd3; rd_addr[2] = 3'd6; rd_addr[3] = 3'd5;
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        do_reset();

        // Fresh array reads zero; then write/read ordering across requesters.
        req_once(0, 1'b0, 3'd5, 32'h0);
        req_once(0, 1'b1, 3'd3, 32'hDEADBEEF);
        req_once(1, 1'b0, 3'd3, 32'h0);
        check("rsp0_hold", bus.rsp0_rdata, 32'hDEADBEEF);
        check("rsp1_hold", bus.rsp1_rdata, 32'hDEADBEEF);

        // Tie straight after reset, both held: grants must alternate 0,1,0,1.
        do_reset();
        @(posedge clk); #2;
        drive(0, 1'b1, 3'd6, 32'hA0A0_0000);
        drive(1, 1'b0, 3'd6, 32'h0);
        base = gid.size();
        for (int k = 0; k < 4; k++) begin
            wait_grants(base + k + 1);
            w = (gid.size() > 0) ? gid[gid.size()-1] : 0;
            @(posedge clk); #2;
            if (w == 0) drive(0, 1'b1, 3'd6, 32'hA0A0_0000 + 32'(k + 1));
            else        drive(1, 1'b0, 3'd6, 32'h0);
        end
        drop(0);
        drop(1);
        drain();
        if (gid.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("tie_grant_order", gid[base+k], k % 2);
                if (k > 0) check("tie_grant_spacing", gcyc[base+k] - gcyc[base+k-1], 32'd3);
            end
        end

        // Single requester back-to-back reads: accepts every third cycle.
        @(posedge clk); #2;
        drive(1, 1'b0, rd_addr[0], 32'h0);
        base = gid.size();
        for (int k = 0; k < 4; k++) begin
            wait_grants(base + k + 1);
            @(posedge clk); #2;
            if (k < 3) drive(1, 1'b0, rd_addr[k+1], 32'h0);
            else       drop(1);
        end
        drain();
        if (gid.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("single_grant_id", gid[base+k], 32'd1);
                if (k > 0) check("single_grant_spacing", gcyc[base+k] - gcyc[base+k-1], 32'd3);
            end
        end

        // Reset during ACCESS of a write drops it: no response, array stays zero.
        @(posedge clk); #2;
        drive(0, 1'b1, 3'd2, 32'h1234_5678);
        base = gid.size();
        wait_grants(base + 1);
        @(posedge clk); #2;
        check("busy_in_access", 32'(busy), 32'd1);
        reset = 1'b0;
        drop(0);
        #1;
        check("midop_busy", 32'(busy), 32'd0);
        check("midop_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        req_once(1, 1'b0, 3'd2, 32'h0);
        check("midop_readback", bus.rsp1_rdata, 32'd0);

        repeat (5) @(negedge clk);
        #1;
        check("final_queues_empty", q0.size() + q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
